// File: rtl/bus_drvr_endpoint.sv
// Driver-side endpoint of the parallel bus: a TX FIFO feeding the arbiter's
// pndng/pop/D_pop port and an ID-filtered RX FIFO fed by its push/D_push port.
// Both FIFOs are first-word-fall-through; TX and RX are fully independent.
module bus_drvr_endpoint #(
  parameter int         bits      = 32,
  parameter int         depth     = 8,
  parameter logic [7:0] drvr_id   = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic            clk,
  input  logic            reset,
  // device -> TX FIFO
  input  logic            tx_push,
  input  logic [bits-1:0] tx_data,
  output logic            tx_full,
  // TX FIFO -> arbiter
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  // arbiter -> RX FIFO
  input  logic            push,
  input  logic [bits-1:0] D_push,
  // RX FIFO -> device
  output logic            rx_pndng,
  output logic [bits-1:0] rx_data,
  input  logic            rx_pop,
  output logic            rx_ovf,
  input  logic            rx_ovf_clr,
  output logic [15:0]     rx_drop_cnt
);

  localparam int               ptr_w    = $clog2(depth);
  localparam logic [ptr_w:0]   full_cnt = (ptr_w + 1)'(depth);

  typedef logic [bits-1:0] word_t;

  // ---------------------------------------------------------------- TX side
  word_t            tx_mem [depth];
  logic [ptr_w-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [ptr_w:0]   tx_cnt, tx_cnt_nxt;
  logic             tx_push_ok, tx_pop_ok;

  // Status flags come straight from the registered count, so pndng and
  // tx_full never depend combinationally on pop or tx_push.
  assign pndng   = (tx_cnt != '0);
  assign tx_full = (tx_cnt == full_cnt);
  assign D_pop   = tx_mem[tx_rd_ptr];

  // A push into a full FIFO is still taken if the head leaves this cycle.
  assign tx_pop_ok  = pop && pndng;
  assign tx_push_ok = tx_push && (!tx_full || tx_pop_ok);

  // Next TX occupancy from the accepted handshakes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    tx_cnt_nxt = tx_cnt;
    unique case ({tx_push_ok, tx_pop_ok})
      2'b10:   tx_cnt_nxt = tx_cnt + 1'b1;
      2'b01:   tx_cnt_nxt = tx_cnt - 1'b1;
      default: tx_cnt_nxt = tx_cnt;
    endcase
  end

  // TX pointers and count; reset discards any buffered words.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_cnt <= tx_cnt_nxt;
    end
  end

  // TX storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the count alone decides which entries are valid.
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= tx_data;
  end

  // ---------------------------------------------------------------- RX side
  word_t            rx_mem [depth];
  logic [ptr_w-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [ptr_w:0]   rx_cnt, rx_cnt_nxt;
  logic             rx_full;
  logic [7:0]       dst;
  logic             addressed, rx_push_ok, rx_pop_ok, drop, ovf_set;

  assign rx_pndng = (rx_cnt != '0);
  assign rx_full  = (rx_cnt == full_cnt);
  assign rx_data  = rx_mem[rx_rd_ptr];

  // Destination filter and accept/drop decision for a delivered word.
  assign dst        = D_push[bits-1 -: 8];
  assign addressed  = (dst == drvr_id) || (dst == broadcast);
  assign rx_pop_ok  = rx_pop && rx_pndng;
  assign rx_push_ok = push && addressed && (!rx_full || rx_pop_ok);
  assign drop       = push && !rx_push_ok;
  assign ovf_set    = push && addressed && !rx_push_ok;

  // Next RX occupancy from the accepted handshakes.
  always_comb begin
    rx_cnt_nxt = rx_cnt;
    unique case ({rx_push_ok, rx_pop_ok})
      2'b10:   rx_cnt_nxt = rx_cnt + 1'b1;
      2'b01:   rx_cnt_nxt = rx_cnt - 1'b1;
      default: rx_cnt_nxt = rx_cnt;
    endcase
  end

  // RX pointers and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_cnt <= rx_cnt_nxt;
    end
  end

  // RX storage write.
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= D_push;
  end

  // Sticky overflow flag (a new overflow beats a same-cycle clear) and
  // saturating drop counter covering both overflow and misaddressed drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ovf      <= 1'b0;
      rx_drop_cnt <= '0;
    end else begin
      if (ovf_set)         rx_ovf <= 1'b1;
      else if (rx_ovf_clr) rx_ovf <= 1'b0;
      if (drop && (rx_drop_cnt != 16'hFFFF)) rx_drop_cnt <= rx_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_drvr_endpoint.sv
// Directed bench for bus_drvr_endpoint (drvr_id = 3, depth = 8, bits = 32).
module tb_bus_drvr_endpoint;

  localparam int bits = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            tx_push, pop, push, rx_pop, rx_ovf_clr;
  logic [bits-1:0] tx_data, D_push;
  logic            tx_full, pndng, rx_pndng, rx_ovf;
  logic [bits-1:0] D_pop, rx_data;
  logic [15:0]     rx_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bus_drvr_endpoint #(.bits(bits), .depth(8), .drvr_id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_pndng(rx_pndng), .rx_data(rx_data), .rx_pop(rx_pop),
    .rx_ovf(rx_ovf), .rx_ovf_clr(rx_ovf_clr), .rx_drop_cnt(rx_drop_cnt)
  );

  function automatic logic [bits-1:0] mk(input logic [7:0] d, input int v);
    logic [31:0] vv;
    vv = v;
    return {d, vv[23:0]};
  endfunction

  // Advance one edge and settle 1 time unit past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_push = 0; pop = 0; push = 0; rx_pop = 0; rx_ovf_clr = 0;
    tx_data = '0; D_push = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    total_cnt++; if (pndng !== 1'b0) $display("FAIL reset_pndng got %b exp 0", pndng); else pass_cnt++;
    total_cnt++; if (tx_full !== 1'b0) $display("FAIL reset_tx_full got %b exp 0", tx_full); else pass_cnt++;
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL reset_rx_pndng got %b exp 0", rx_pndng); else pass_cnt++;
    total_cnt++; if (rx_ovf !== 1'b0) $display("FAIL reset_rx_ovf got %b exp 0", rx_ovf); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt got %h exp 0000", rx_drop_cnt); else pass_cnt++;
  endtask

  task automatic test_tx_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      tx_push = 1; tx_data = mk(8'h00, i);
      step();
      total_cnt++; if (pndng !== 1'b1) $display("FAIL fill_pndng[%0d] got %b exp 1", i, pndng); else pass_cnt++;
      total_cnt++; if (D_pop !== mk(8'h00, 1)) $display("FAIL fill_head[%0d] got %h exp %h", i, D_pop, mk(8'h00, 1)); else pass_cnt++;
      total_cnt++; if (tx_full !== (i == 8)) $display("FAIL fill_full[%0d] got %b exp %b", i, tx_full, (i == 8)); else pass_cnt++;
    end
    // 9th push while full and no pop: ignored
    tx_data = mk(8'h00, 9);
    step();
    tx_push = 0;
    total_cnt++; if (tx_full !== 1'b1) $display("FAIL ovf_push_full got %b exp 1", tx_full); else pass_cnt++;
    for (int i = 1; i <= 8; i++) begin
      total_cnt++; if (D_pop !== mk(8'h00, i)) $display("FAIL drain_data[%0d] got %h exp %h", i, D_pop, mk(8'h00, i)); else pass_cnt++;
      pop = 1;
      step();
      pop = 0;
      total_cnt++; if (tx_full !== 1'b0) $display("FAIL drain_full[%0d] got %b exp 0", i, tx_full); else pass_cnt++;
    end
    total_cnt++; if (pndng !== 1'b0) $display("FAIL drain_pndng got %b exp 0", pndng); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      tx_push = 1; tx_data = mk(8'h00, 8'h10 + i);
      step();
    end
    // full FIFO: push + pop in the same cycle
    tx_data = mk(8'h00, 8'h99); pop = 1;
    step();
    tx_push = 0; pop = 0;
    total_cnt++; if (tx_full !== 1'b1) $display("FAIL b2b_full got %b exp 1", tx_full); else pass_cnt++;
    for (int i = 2; i <= 8; i++) begin
      total_cnt++; if (D_pop !== mk(8'h00, 8'h10 + i)) $display("FAIL b2b_data[%0d] got %h exp %h", i, D_pop, mk(8'h00, 8'h10 + i)); else pass_cnt++;
      pop = 1; step(); pop = 0;
    end
    total_cnt++; if (D_pop !== mk(8'h00, 8'h99)) $display("FAIL b2b_last got %h exp %h", D_pop, mk(8'h00, 8'h99)); else pass_cnt++;
    pop = 1; step();
    total_cnt++; if (pndng !== 1'b0) $display("FAIL b2b_empty got %b exp 0", pndng); else pass_cnt++;
    // pop while empty: ignored
    step(); pop = 0;
    total_cnt++; if (pndng !== 1'b0) $display("FAIL empty_pop_pndng got %b exp 0", pndng); else pass_cnt++;
    tx_push = 1; tx_data = mk(8'h00, 8'h55); step(); tx_push = 0;
    total_cnt++; if (D_pop !== mk(8'h00, 8'h55)) $display("FAIL empty_pop_after got %h exp %h", D_pop, mk(8'h00, 8'h55)); else pass_cnt++;
    pop = 1; step(); pop = 0;
    total_cnt++; if (pndng !== 1'b0) $display("FAIL empty_pop_final got %b exp 0", pndng); else pass_cnt++;
  endtask

  task automatic test_rx_filter();
    push = 1;
    D_push = mk(8'h03, 1); step();
    total_cnt++; if (rx_pndng !== 1'b1) $display("FAIL filt_pndng got %b exp 1", rx_pndng); else pass_cnt++;
    total_cnt++; if (rx_data !== mk(8'h03, 1)) $display("FAIL filt_own got %h exp %h", rx_data, mk(8'h03, 1)); else pass_cnt++;
    D_push = mk(8'hFF, 2); step();
    D_push = mk(8'h05, 3); step();
    push = 0;
    total_cnt++; if (rx_drop_cnt !== 16'd1) $display("FAIL filt_drop got %h exp 0001", rx_drop_cnt); else pass_cnt++;
    total_cnt++; if (rx_ovf !== 1'b0) $display("FAIL filt_ovf got %b exp 0", rx_ovf); else pass_cnt++;
    rx_pop = 1; step();
    total_cnt++; if (rx_data !== mk(8'hFF, 2)) $display("FAIL filt_bcast got %h exp %h", rx_data, mk(8'hFF, 2)); else pass_cnt++;
    step(); rx_pop = 0;
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL filt_empty got %b exp 0", rx_pndng); else pass_cnt++;
  endtask

  task automatic test_rx_overflow();
    push = 1;
    for (int i = 1; i <= 8; i++) begin
      D_push = mk(8'h03, 8'h20 + i); step();
    end
    total_cnt++; if (rx_ovf !== 1'b0) $display("FAIL ovf_before got %b exp 0", rx_ovf); else pass_cnt++;
    D_push = mk(8'h03, 8'h99); step();
    total_cnt++; if (rx_ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", rx_ovf); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'd2) $display("FAIL ovf_drop got %h exp 0002", rx_drop_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== mk(8'h03, 8'h21)) $display("FAIL ovf_head got %h exp %h", rx_data, mk(8'h03, 8'h21)); else pass_cnt++;
    // full + same-cycle rx_pop: accepted
    D_push = mk(8'h03, 8'hAA); rx_pop = 1; step(); rx_pop = 0;
    total_cnt++; if (rx_drop_cnt !== 16'd2) $display("FAIL ovf_pop_drop got %h exp 0002", rx_drop_cnt); else pass_cnt++;
    total_cnt++; if (rx_data !== mk(8'h03, 8'h22)) $display("FAIL ovf_pop_head got %h exp %h", rx_data, mk(8'h03, 8'h22)); else pass_cnt++;
    // clear and new overflow together: set wins
    D_push = mk(8'h03, 8'hBB); rx_ovf_clr = 1; step(); push = 0;
    total_cnt++; if (rx_ovf !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", rx_ovf); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'd3) $display("FAIL ovf_drop3 got %h exp 0003", rx_drop_cnt); else pass_cnt++;
    step(); rx_ovf_clr = 0;
    total_cnt++; if (rx_ovf !== 1'b0) $display("FAIL ovf_clr got %b exp 0", rx_ovf); else pass_cnt++;
    for (int i = 2; i <= 8; i++) begin
      total_cnt++; if (rx_data !== mk(8'h03, 8'h20 + i)) $display("FAIL ovf_drain[%0d] got %h exp %h", i, rx_data, mk(8'h03, 8'h20 + i)); else pass_cnt++;
      rx_pop = 1; step(); rx_pop = 0;
    end
    total_cnt++; if (rx_data !== mk(8'h03, 8'hAA)) $display("FAIL ovf_last got %h exp %h", rx_data, mk(8'h03, 8'hAA)); else pass_cnt++;
    rx_pop = 1; step();
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL ovf_empty got %b exp 0", rx_pndng); else pass_cnt++;
    step(); rx_pop = 0;
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL rx_empty_pop got %b exp 0", rx_pndng); else pass_cnt++;
  endtask

  task automatic test_drop_saturate();
    // count is 3 here; 65531 more drops reach 16'hFFFE
    push = 1; D_push = mk(8'h05, 8'h77);
    repeat (65531) step();
    total_cnt++; if (rx_drop_cnt !== 16'hFFFE) $display("FAIL sat_near got %h exp fffe", rx_drop_cnt); else pass_cnt++;
    step();
    total_cnt++; if (rx_drop_cnt !== 16'hFFFF) $display("FAIL sat_reach got %h exp ffff", rx_drop_cnt); else pass_cnt++;
    repeat (70000 - 65532) step();
    push = 0;
    total_cnt++; if (rx_drop_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", rx_drop_cnt); else pass_cnt++;
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL sat_rx_pndng got %b exp 0", rx_pndng); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    tx_push = 1; push = 1;
    for (int i = 0; i < 4; i++) begin
      tx_data = mk(8'h00, 8'h40 + i); D_push = mk(8'h03, 8'h50 + i); step();
    end
    // all four handshakes in one cycle
    tx_data = mk(8'h00, 8'h44); D_push = mk(8'h03, 8'h54); pop = 1; rx_pop = 1;
    step();
    idle_inputs();
    total_cnt++; if (D_pop !== mk(8'h00, 8'h41)) $display("FAIL conc_tx got %h exp %h", D_pop, mk(8'h00, 8'h41)); else pass_cnt++;
    total_cnt++; if (rx_data !== mk(8'h03, 8'h51)) $display("FAIL conc_rx got %h exp %h", rx_data, mk(8'h03, 8'h51)); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'hFFFF) $display("FAIL conc_drop got %h exp ffff", rx_drop_cnt); else pass_cnt++;
    #2 reset = 0;
    #1;
    total_cnt++; if (pndng !== 1'b0) $display("FAIL arst_pndng got %b exp 0", pndng); else pass_cnt++;
    total_cnt++; if (rx_pndng !== 1'b0) $display("FAIL arst_rx_pndng got %b exp 0", rx_pndng); else pass_cnt++;
    total_cnt++; if (tx_full !== 1'b0) $display("FAIL arst_tx_full got %b exp 0", tx_full); else pass_cnt++;
    total_cnt++; if (rx_ovf !== 1'b0) $display("FAIL arst_rx_ovf got %b exp 0", rx_ovf); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'h0) $display("FAIL arst_drop got %h exp 0000", rx_drop_cnt); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    tx_push = 1; tx_data = mk(8'h00, 8'h77); push = 1; D_push = mk(8'h03, 8'h88);
    step();
    push = 1; tx_push = 0; D_push = mk(8'h06, 8'h99);
    step();
    idle_inputs();
    total_cnt++; if (D_pop !== mk(8'h00, 8'h77)) $display("FAIL post_tx got %h exp %h", D_pop, mk(8'h00, 8'h77)); else pass_cnt++;
    total_cnt++; if (rx_data !== mk(8'h03, 8'h88)) $display("FAIL post_rx got %h exp %h", rx_data, mk(8'h03, 8'h88)); else pass_cnt++;
    total_cnt++; if (rx_drop_cnt !== 16'd1) $display("FAIL post_drop got %h exp 0001", rx_drop_cnt); else pass_cnt++;
    pop = 1; rx_pop = 1; step(); idle_inputs();
    total_cnt++; if ({pndng, rx_pndng} !== 2'b00) $display("FAIL post_empty got %b exp 00", {pndng, rx_pndng}); else pass_cnt++;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #2;
    test_reset();
    test_tx_fill_drain();
    test_back_to_back();
    test_rx_filter();
    test_rx_overflow();
    test_drop_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
